// File: rtl/tlb_pkg.sv
// Shared widths, flush-mode encodings, flush FSM states and the TLB tag type.
package tlb_pkg;

   localparam int unsigned VPN2W = 19;
   localparam int unsigned ASIDW = 8;
   localparam int unsigned CW    = 3;

   localparam logic [1:0] FLUSH_ALL  = 2'd0;
   localparam logic [1:0] FLUSH_ASID = 2'd1;
   localparam logic [1:0] FLUSH_NG   = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WALK = 2'd1,
      ST_DONE = 2'd2
   } flush_state_t;

   typedef struct packed {
      logic [VPN2W-1:0] vpn2;
      logic [ASIDW-1:0] asid;
      logic             g;
   } tlb_tag_t;

   // Tag compare; presence is qualified separately by the caller.
   function automatic logic tag_match(input tlb_tag_t tag, input logic [VPN2W-1:0] vpn2,
                                      input logic [ASIDW-1:0] asid);
      return (vpn2 == tag.vpn2) && ((asid == tag.asid) || tag.g);
   endfunction

endpackage

// File: rtl/tlb_search_port.sv
// One registered TLB search port: match vector, lowest-index select, multi-hit flag, page mux.
module tlb_search_port
   import tlb_pkg::*;
#(
   parameter  int unsigned TLBNUM = 16,
   parameter  int unsigned PFNW   = 20,
   localparam int unsigned IW     = $clog2(TLBNUM),
   localparam int unsigned PGW    = PFNW + CW + 2
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_req,
   input  logic [VPN2W-1:0]     i_vpn2,
   input  logic                 i_odd_page,
   input  logic [ASIDW-1:0]     i_asid,
   input  logic [TLBNUM-1:0]    i_e,
   input  tlb_tag_t             i_tag   [TLBNUM],
   input  logic [PGW-1:0]       i_page0 [TLBNUM],
   input  logic [PGW-1:0]       i_page1 [TLBNUM],
   output logic                 o_rvalid,
   output logic                 o_found,
   output logic                 o_multi,
   output logic [IW-1:0]        o_index,
   output logic [PFNW-1:0]      o_pfn,
   output logic [CW-1:0]        o_c,
   output logic                 o_d,
   output logic                 o_v
);

   logic [TLBNUM-1:0] w_match;
   logic              w_hit;
   logic              w_multi;
   logic [IW-1:0]     w_idx;
   logic [PGW-1:0]    w_page;

   logic              r_rvalid;
   logic              r_found;
   logic              r_multi;
   logic [IW-1:0]     r_index;
   logic [PGW-1:0]    r_page;

   // Scan entries low to high: first hit gives the index, any later hit flags multi.
   always_comb begin
      w_match = '0;
      w_hit   = 1'b0;
      w_multi = 1'b0;
      w_idx   = '0;
      for (int i = 0; i < int'(TLBNUM); i++) begin
         w_match[i] = i_e[i] && tag_match(i_tag[i], i_vpn2, i_asid);
         if (w_match[i]) begin
            if (w_hit) w_multi = 1'b1;
            else       w_idx   = IW'(i);
            w_hit = 1'b1;
         end
      end
   end

   // Page mux; a miss returns all-zero attributes.
   always_comb begin
      w_page = '0;
      if (w_hit) w_page = i_odd_page ? i_page1[w_idx] : i_page0[w_idx];
   end

   // Result registers: rvalid pulses per request, payload holds until the next request.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rvalid <= 1'b0;
         r_found  <= 1'b0;
         r_multi  <= 1'b0;
         r_index  <= '0;
         r_page   <= '0;
      end else begin
         r_rvalid <= i_req;
         if (i_req) begin
            r_found <= w_hit;
            r_multi <= w_multi;
            r_index <= w_idx;
            r_page  <= w_page;
         end
      end
   end

   assign o_rvalid = r_rvalid;
   assign o_found  = r_found;
   assign o_multi  = r_multi;
   assign o_index  = r_index;
   assign o_pfn    = r_page[PGW-1:CW+2];
   assign o_c      = r_page[CW+1:2];
   assign o_d      = r_page[1];
   assign o_v      = r_page[0];

endmodule

// File: rtl/tlb_ctrl.sv
// Fully associative dual-page TLB: entry array, write/read ports, flush engine, Random counter.
module tlb_ctrl
   import tlb_pkg::*;
#(
   parameter  int unsigned TLBNUM = 16,
   parameter  int unsigned PFNW   = 20,
   localparam int unsigned IW     = $clog2(TLBNUM)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_s0_req,
   input  logic [VPN2W-1:0] i_s0_vpn2,
   input  logic             i_s0_odd_page,
   input  logic [ASIDW-1:0] i_s0_asid,
   output logic             o_s0_rvalid,
   output logic             o_s0_found,
   output logic             o_s0_multi,
   output logic [IW-1:0]    o_s0_index,
   output logic [PFNW-1:0]  o_s0_pfn,
   output logic [CW-1:0]    o_s0_c,
   output logic             o_s0_d,
   output logic             o_s0_v,
   input  logic             i_s1_req,
   input  logic [VPN2W-1:0] i_s1_vpn2,
   input  logic             i_s1_odd_page,
   input  logic [ASIDW-1:0] i_s1_asid,
   output logic             o_s1_rvalid,
   output logic             o_s1_found,
   output logic             o_s1_multi,
   output logic [IW-1:0]    o_s1_index,
   output logic [PFNW-1:0]  o_s1_pfn,
   output logic [CW-1:0]    o_s1_c,
   output logic             o_s1_d,
   output logic             o_s1_v,
   input  logic             i_we,
   input  logic [IW-1:0]    i_w_index,
   input  logic [VPN2W-1:0] i_w_vpn2,
   input  logic [ASIDW-1:0] i_w_asid,
   input  logic             i_w_g,
   input  logic [PFNW-1:0]  i_w_pfn0,
   input  logic [CW-1:0]    i_w_c0,
   input  logic             i_w_d0,
   input  logic             i_w_v0,
   input  logic [PFNW-1:0]  i_w_pfn1,
   input  logic [CW-1:0]    i_w_c1,
   input  logic             i_w_d1,
   input  logic             i_w_v1,
   input  logic [IW-1:0]    i_r_index,
   output logic             o_r_e,
   output logic [VPN2W-1:0] o_r_vpn2,
   output logic [ASIDW-1:0] o_r_asid,
   output logic             o_r_g,
   output logic [PFNW-1:0]  o_r_pfn0,
   output logic [CW-1:0]    o_r_c0,
   output logic             o_r_d0,
   output logic             o_r_v0,
   output logic [PFNW-1:0]  o_r_pfn1,
   output logic [CW-1:0]    o_r_c1,
   output logic             o_r_d1,
   output logic             o_r_v1,
   input  logic             i_flush_req,
   input  logic [1:0]       i_flush_mode,
   input  logic [ASIDW-1:0] i_flush_asid,
   output logic             o_flush_busy,
   output logic             o_flush_done,
   input  logic [IW-1:0]    i_wired,
   output logic [IW-1:0]    o_rand_index
);

   localparam int unsigned PGW = PFNW + CW + 2;

   tlb_tag_t           r_tag   [TLBNUM];
   logic [PGW-1:0]     r_page0 [TLBNUM];
   logic [PGW-1:0]     r_page1 [TLBNUM];
   logic [TLBNUM-1:0]  r_e;

   flush_state_t       r_state;
   logic [IW-1:0]      r_ptr;
   logic [1:0]         r_mode;
   logic [ASIDW-1:0]   r_fasid;
   logic               r_busy;
   logic               r_done;
   logic [IW-1:0]      r_rand;

   logic               w_qual;
   logic               w_flush_clr;

   // Entry payload write; tags and pages are not reset, presence bits guard them.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_tag[i_w_index]   <= tlb_tag_t'{vpn2: i_w_vpn2, asid: i_w_asid, g: i_w_g};
         r_page0[i_w_index] <= {i_w_pfn0, i_w_c0, i_w_d0, i_w_v0};
         r_page1[i_w_index] <= {i_w_pfn1, i_w_c1, i_w_d1, i_w_v1};
      end
   end

   // Does the entry under the flush pointer qualify for invalidation in the latched mode.
   always_comb begin
      w_qual = 1'b1;
      case (r_mode)
         FLUSH_ASID: w_qual = !r_tag[r_ptr].g && (r_tag[r_ptr].asid == r_fasid);
         FLUSH_NG:   w_qual = !r_tag[r_ptr].g;
         default:    w_qual = 1'b1;
      endcase
      w_flush_clr = (r_state == ST_WALK) && w_qual;
   end

   // Presence bits: flush clears, a same-cycle write to the same entry wins.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_e <= '0;
      end else begin
         if (w_flush_clr) r_e[r_ptr] <= 1'b0;
         if (i_we)        r_e[i_w_index] <= 1'b1;
      end
   end

   // Flush engine: latch request in IDLE, walk one entry per cycle, pulse done once.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_mode  <= FLUSH_ALL;
         r_fasid <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_flush_req) begin
                  r_state <= ST_WALK;
                  r_ptr   <= '0;
                  r_mode  <= i_flush_mode;
                  r_fasid <= i_flush_asid;
                  r_busy  <= 1'b1;
               end
            end
            ST_WALK: begin
               if (r_ptr == IW'(TLBNUM - 1)) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_ptr <= r_ptr + IW'(1);
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Random index: free-running down-count inside [wired, TLBNUM-1].
   always_ff @(posedge i_clk) begin
      if (i_reset)                r_rand <= IW'(TLBNUM - 1);
      else if (r_rand <= i_wired) r_rand <= IW'(TLBNUM - 1);
      else                        r_rand <= r_rand - IW'(1);
   end

   tlb_search_port #(.TLBNUM(TLBNUM), .PFNW(PFNW)) u_s0 (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_req      (i_s0_req),
      .i_vpn2     (i_s0_vpn2),
      .i_odd_page (i_s0_odd_page),
      .i_asid     (i_s0_asid),
      .i_e        (r_e),
      .i_tag      (r_tag),
      .i_page0    (r_page0),
      .i_page1    (r_page1),
      .o_rvalid   (o_s0_rvalid),
      .o_found    (o_s0_found),
      .o_multi    (o_s0_multi),
      .o_index    (o_s0_index),
      .o_pfn      (o_s0_pfn),
      .o_c        (o_s0_c),
      .o_d        (o_s0_d),
      .o_v        (o_s0_v)
   );

   tlb_search_port #(.TLBNUM(TLBNUM), .PFNW(PFNW)) u_s1 (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_req      (i_s1_req),
      .i_vpn2     (i_s1_vpn2),
      .i_odd_page (i_s1_odd_page),
      .i_asid     (i_s1_asid),
      .i_e        (r_e),
      .i_tag      (r_tag),
      .i_page0    (r_page0),
      .i_page1    (r_page1),
      .o_rvalid   (o_s1_rvalid),
      .o_found    (o_s1_found),
      .o_multi    (o_s1_multi),
      .o_index    (o_s1_index),
      .o_pfn      (o_s1_pfn),
      .o_c        (o_s1_c),
      .o_d        (o_s1_d),
      .o_v        (o_s1_v)
   );

   assign o_r_e        = r_e[i_r_index];
   assign o_r_vpn2     = r_tag[i_r_index].vpn2;
   assign o_r_asid     = r_tag[i_r_index].asid;
   assign o_r_g        = r_tag[i_r_index].g;
   assign o_r_pfn0     = r_page0[i_r_index][PGW-1:CW+2];
   assign o_r_c0       = r_page0[i_r_index][CW+1:2];
   assign o_r_d0       = r_page0[i_r_index][1];
   assign o_r_v0       = r_page0[i_r_index][0];
   assign o_r_pfn1     = r_page1[i_r_index][PGW-1:CW+2];
   assign o_r_c1       = r_page1[i_r_index][CW+1:2];
   assign o_r_d1       = r_page1[i_r_index][1];
   assign o_r_v1       = r_page1[i_r_index][0];
   assign o_flush_busy = r_busy;
   assign o_flush_done = r_done;
   assign o_rand_index = r_rand;

endmodule
